// File: rtl/sfifo_nf.sv
// sfifo_nf: DEPTH-entry flop-based synchronous FIFO with show-ahead output.
//   dout always shows the head entry and is meaningful only while empty==0.
//   The status flags, count and pointers are registered. Each flag is derived
//   from the post-edge occupancy.
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   din, wr           write data / write request
//   rd                pop the head entry
//   clr_err           synchronous clear of the sticky error flags
//   dout              head entry
//   full, empty       count == DEPTH / count == 0
//   almost_full       count >= AF_LEVEL
//   almost_empty      count <= AE_LEVEL
//   count             occupancy 0..DEPTH
//   overflow          sticky: a write was dropped
//   underflow         sticky: a read was ignored
module sfifo_nf #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int DEPTH_BITS = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [DEPTH_BITS:0]   DEPTH_C = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   AF_C    = (DEPTH_BITS+1)'(AF_LEVEL);
  localparam logic [DEPTH_BITS:0]   AE_C    = (DEPTH_BITS+1)'(AE_LEVEL);
  localparam logic [DEPTH_BITS-1:0] PTR_MAX = DEPTH_BITS'(DEPTH-1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_ok, rd_ok;

  // A write into a full FIFO is legal only when the head pops in the same edge.
  // A read of an empty FIFO never pops, even alongside a write.
  assign wr_ok = wr & (~full_q | rd);
  assign rd_ok = rd & ~empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_ok) begin
      mem_d[wr_ptr_q] = din;
      // Wrap explicitly so that non-power-of-two depths work.
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_ok)
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    // A new error in the same cycle as clr_err takes priority over the clear.
    ovf_d = (ovf_q & ~clr_err) | (wr & full_q & ~rd);
    udf_d = (udf_q & ~clr_err) | (rd & empty_q);
  end

  // Storage is not reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign dout         = mem_q[rd_ptr_q];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sfifo_nf.sv
// tb_sfifo_nf: two sfifo_nf instances share one stimulus bus: DEPTH=4
// (AF=3, AE=1) and DEPTH=3 (AF=2, AE=1). The variable sel selects which
// instance the reference model tracks and the monitor checks. A behavioural
// queue model updates at each clock edge. A monitor compares every output
// against it half a cycle later, and again just after any reset falling edge.
module tb_sfifo_nf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  int          sel = 0;

  logic [15:0] dout4, dout3, dout_m;
  logic        full4, empty4, af4, ae4, ovf4, udf4;
  logic        full3, empty3, af3, ae3, ovf3, udf3;
  logic        full_m, empty_m, af_m, ae_m, ovf_m, udf_m;
  logic [2:0]  count4, count3, count_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sfifo_nf #(.WIDTH(16), .DEPTH(4), .DEPTH_BITS(2), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .wr(wr), .rd(rd), .clr_err(clr_err),
    .dout(dout4), .full(full4), .empty(empty4), .almost_full(af4), .almost_empty(ae4),
    .count(count4), .overflow(ovf4), .underflow(udf4));

  sfifo_nf #(.WIDTH(16), .DEPTH(3), .DEPTH_BITS(2), .AF_LEVEL(2), .AE_LEVEL(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .wr(wr), .rd(rd), .clr_err(clr_err),
    .dout(dout3), .full(full3), .empty(empty3), .almost_full(af3), .almost_empty(ae3),
    .count(count3), .overflow(ovf3), .underflow(udf3));

  always_comb begin
    if (sel == 0) begin
      dout_m = dout4; full_m = full4; empty_m = empty4; af_m = af4; ae_m = ae4;
      count_m = count4; ovf_m = ovf4; udf_m = udf4;
    end else begin
      dout_m = dout3; full_m = full3; empty_m = empty3; af_m = af3; ae_m = ae3;
      count_m = count3; ovf_m = ovf3; udf_m = udf3;
    end
  end

  // Reference model: a plain queue of stored words plus the two sticky bits.
  logic [15:0] mdl_q[$];
  bit          m_ovf = 0, m_udf = 0;
  int          m_depth, m_af, m_ae;
  assign m_depth = (sel == 0) ? 4 : 3;
  assign m_af    = (sel == 0) ? 3 : 2;
  assign m_ae    = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      int  n;
      bit  do_wr, do_rd;
      n     = mdl_q.size();
      do_wr = wr && ((n < m_depth) || rd);
      do_rd = rd && (n > 0);
      if (clr_err) begin m_ovf = 0; m_udf = 0; end
      if (wr && n == m_depth && !rd) m_ovf = 1;
      if (rd && n == 0) m_udf = 1;
      if (do_rd) void'(mdl_q.pop_front());
      if (do_wr) mdl_q.push_back(din);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (sel=%0d t=%0t): got %0h, expected %0h", nm, sel, $time, act, exp);
    end
  endtask

  // Monitor: compare the DUT against the model away from the active clock edge.
  always begin
    int n;
    @(negedge clk or negedge rst_n);
    #1;
    n = mdl_q.size();
    chk("count",        int'(count_m), n);
    chk("full",         int'(full_m),  int'(n == m_depth));
    chk("empty",        int'(empty_m), int'(n == 0));
    chk("almost_full",  int'(af_m),    int'(n >= m_af));
    chk("almost_empty", int'(ae_m),    int'(n <= m_ae));
    chk("overflow",     int'(ovf_m),   int'(m_ovf));
    chk("underflow",    int'(udf_m),   int'(m_udf));
    if (n > 0) chk("dout", int'(dout_m), int'(mdl_q[0]));
  end

  task automatic drive(input bit w, input bit r, input bit c, input logic [15:0] d);
    wr = w; rd = r; clr_err = c; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int s);
    wr = 0; rd = 0; clr_err = 0;
    rst_n = 1'b0;
    sel = s;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_run(input int cycles, input int pw, input int pr);
    for (int i = 0; i < cycles; i++)
      drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            $urandom_range(0, 99) < 5, 16'($urandom));
  endtask

  initial begin
    // DEPTH=4 instance.
    do_reset(0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 16'hA0 + 16'(i));  // fill: A0..A3
    drive(1, 1, 0, 16'h00B0);                                     // full, wr&rd
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 16'h0);            // A1 A2 A3 B0
    drive(1, 1, 0, 16'h00C0);                                     // empty, wr&rd
    drive(0, 0, 1, 16'h0);                                        // clear underflow
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 16'hD0 + 16'(i));
    drive(1, 0, 0, 16'h00EE);                                     // overflow
    drive(0, 0, 1, 16'h0);
    drive(1, 0, 1, 16'h00EF);                                     // clear vs new overflow
    drive(0, 1, 1, 16'h0);
    drive(0, 1, 0, 16'h0);
    rand_run(300, 55, 45);
    rand_run(200, 40, 60);

    // Reset pulsed mid-operation with count=2 and a write pending.
    do_reset(0);
    drive(1, 0, 0, 16'h0011);
    drive(1, 0, 0, 16'h0022);
    wr = 1; rd = 0; din = 16'h0033;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 16'h0);

    // DEPTH=3 instance: interleaved traffic wraps the pointers.
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 16'h0100 + 16'(i));
      drive(1, 1, 0, 16'h0200 + 16'(i));
      drive(0, 1, 0, 16'h0);
    end
    rand_run(300, 55, 45);
    rand_run(200, 45, 55);
    drive(0, 0, 0, 16'h0);
    drive(0, 0, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
